// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: imem address/data, redirect/halt control and the decode handshake.
interface ifetch_unit_if #(
  parameter int N = 32
);
  logic [N-1:0] imem_addr;
  logic [N-1:0] imem_instr;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         halt;
  logic         dec_valid;
  logic [N-1:0] dec_instr;
  logic [N-1:0] dec_pc;
  logic         dec_ready;

  // Fetch-unit side.
  modport master (
    output imem_addr, dec_valid, dec_instr, dec_pc,
    input  imem_instr, redirect_valid, redirect_pc, halt, dec_ready
  );

  // Core / memory / decode side.
  modport slave (
    input  imem_addr, dec_valid, dec_instr, dec_pc,
    output imem_instr, redirect_valid, redirect_pc, halt, dec_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, combinational imem address, prefetch FIFO toward decode,
// redirect flush and halt control.
module ifetch_unit #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             DEPTH    = 2
) (
  input  logic          clk,
  input  logic          nrst,
  ifetch_unit_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t                    state_q;
  logic [N-1:0]              pc_q;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [AW-1:0]             rd_q, wr_q;
  logic [DEPTH-1:0][N-1:0]   fifo_pc_q;
  logic [DEPTH-1:0][N-1:0]   fifo_instr_q;

  logic full, pop, push;
  logic unused_rpc_lsb;

  // Target low bits are forced to zero; they never reach the PC.
  assign unused_rpc_lsb = ^bus.redirect_pc[1:0];

  assign full  = (cnt_q == CW'(DEPTH));
  assign pop   = bus.dec_valid & bus.dec_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still fetches while decode drains.
  assign push  = (state_q == RUN) & ~bus.halt & ~bus.redirect_valid & (~full | pop);
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  assign bus.imem_addr = {2'b00, pc_q[N-1:2]};
  // Head comes straight from FIFO registers; gated to zero while empty so stale entries never leak.
  assign bus.dec_valid = (cnt_q != '0);
  assign bus.dec_instr = bus.dec_valid ? fifo_instr_q[rd_q] : '0;
  assign bus.dec_pc    = bus.dec_valid ? fifo_pc_q[rd_q]    : '0;

  // Run/halt FSM; a redirect always forces one fetch decision in RUN.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (bus.halt && !bus.redirect_valid) state_q <= HALTED;
        HALTED:  if (!bus.halt || bus.redirect_valid) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // PC, pointers and occupancy; redirect flushes and overrides any push/pop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
    end else if (bus.redirect_valid) begin
      pc_q  <= {bus.redirect_pc[N-1:2], 2'b00};
      cnt_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
    end else begin
      if (push) begin
        pc_q <= pc_q + N'(4);
        wr_q <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage: capture the fetched word with the PC it came from.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fifo_pc_q    <= '0;
      fifo_instr_q <= '0;
    end else if (push) begin
      fifo_pc_q[wr_q]    <= pc_q;
      fifo_instr_q[wr_q] <= bus.imem_instr;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: ordering scoreboard under random back-pressure/redirect/halt,
// a cycle-exact vector table for stall/redirect/halt, PC wrap and async reset.
module tb_ifetch_unit;
  logic clk;
  logic nrst;

  ifetch_unit_if #(.N(32)) bus0();
  ifetch_unit_if #(.N(32)) bus1();

  ifetch_unit #(.N(32), .RESET_PC(32'h0), .DEPTH(2)) dut0 (
    .clk(clk), .nrst(nrst), .bus(bus0.master));
  ifetch_unit #(.N(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut1 (
    .clk(clk), .nrst(nrst), .bus(bus1.master));

  // imem: word k holds 0x1000_0000 + k
  assign bus0.imem_instr = 32'h1000_0000 + bus0.imem_addr;
  assign bus1.imem_instr = 32'h1000_0000 + bus1.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  // Expected decode stream starting at a (byte) target.
  task automatic load_stream(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 100; k++)
      exp_q.push_back({start + 32'(k) * 4, word_at(start + 32'(k) * 4)});
  endtask

  typedef struct {
    logic        rdy, halt, rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc, eaddr;
  } vec_t;
  vec_t vt[23];

  function automatic vec_t mk(input logic rdy, halt, rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, eaddr);
    vec_t v;
    v.rdy = rdy; v.halt = halt; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic drive0(input logic rdy, halt, rv, input logic [31:0] rpc);
    bus0.dec_ready      = rdy;
    bus0.halt           = halt;
    bus0.redirect_valid = rv;
    bus0.redirect_pc    = rpc;
  endtask

  // Reset held over two edges, released just after a rising edge (start of cycle 0).
  task automatic do_reset();
    nrst = 1'b0;
    drive0(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int hs;
    logic rv;
    logic [31:0] rpc;
    exp_t e;

    bus1.dec_ready = 1'b1; bus1.halt = 1'b0;
    bus1.redirect_valid = 1'b0; bus1.redirect_pc = 32'h0;

    // Expected stall/redirect/halt timeline, cycle 0 = first cycle after reset release.
    vt[0]  = mk(0,0,0,32'h0,   0,32'h0,  32'h0);
    vt[1]  = mk(0,0,0,32'h0,   1,32'h0,  32'h1);
    vt[2]  = mk(0,0,0,32'h0,   1,32'h0,  32'h2);
    vt[3]  = mk(0,0,0,32'h0,   1,32'h0,  32'h2);
    vt[4]  = mk(0,0,0,32'h0,   1,32'h0,  32'h2);
    vt[5]  = mk(1,0,0,32'h0,   1,32'h0,  32'h2);
    vt[6]  = mk(1,0,0,32'h0,   1,32'h4,  32'h3);
    vt[7]  = mk(1,0,1,32'h43,  1,32'h8,  32'h4);
    vt[8]  = mk(1,0,0,32'h0,   0,32'h0,  32'h10);
    vt[9]  = mk(1,0,0,32'h0,   1,32'h40, 32'h11);
    vt[10] = mk(0,0,0,32'h0,   1,32'h44, 32'h12);
    vt[11] = mk(1,1,0,32'h0,   1,32'h44, 32'h13);
    vt[12] = mk(1,1,0,32'h0,   1,32'h48, 32'h13);
    vt[13] = mk(1,1,0,32'h0,   0,32'h0,  32'h13);
    vt[14] = mk(1,1,0,32'h0,   0,32'h0,  32'h13);
    vt[15] = mk(1,0,0,32'h0,   0,32'h0,  32'h13);
    vt[16] = mk(1,0,0,32'h0,   0,32'h0,  32'h13);
    vt[17] = mk(1,0,0,32'h0,   1,32'h4c, 32'h14);
    vt[18] = mk(1,1,1,32'h100, 1,32'h50, 32'h15);
    vt[19] = mk(1,1,0,32'h0,   0,32'h0,  32'h40);
    vt[20] = mk(1,0,0,32'h0,   0,32'h0,  32'h40);
    vt[21] = mk(1,0,0,32'h0,   0,32'h0,  32'h40);
    vt[22] = mk(1,0,0,32'h0,   1,32'h100,32'h41);

    // ---- Reset state and streaming scoreboard ----
    do_reset();
    load_stream(32'h0);
    drive0(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rst_valid",  32'(bus0.dec_valid), 32'h0);
    chk("rst_pc",     bus0.dec_pc,         32'h0);
    chk("rst_instr",  bus0.dec_instr,      32'h0);
    chk("rst_addr",   bus0.imem_addr,      32'h0);
    chk("rst1_addr",  bus1.imem_addr,      32'h3FFF_FFFF);

    hs = 0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      rv = 1'b0; rpc = 32'h0;
      if (cyc > 0) begin
        @(posedge clk); #1;
        if (cyc < 10) drive0(1'b1, 1'b0, 1'b0, 32'h0);
        else begin
          rv  = ($urandom_range(0, 11) == 0);
          rpc = 32'($urandom_range(0, 1023));
          drive0($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rv, rpc);
        end
      end
      @(negedge clk);
      if (cyc >= 1 && cyc < 10) chk("steady_valid", 32'(bus0.dec_valid), 32'h1);
      if (cyc == 1) begin
        chk("wrap_pc0",    bus1.dec_pc,    32'hFFFF_FFFC);
        chk("wrap_instr0", bus1.dec_instr, 32'h4FFF_FFFF);
      end
      if (cyc == 2) begin
        chk("wrap_pc1",    bus1.dec_pc,    32'h0);
        chk("wrap_instr1", bus1.dec_instr, 32'h1000_0000);
      end
      if (bus0.dec_valid && bus0.dec_ready) begin
        hs++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty act_pc=%h exp=none", bus0.dec_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc",    bus0.dec_pc,    e.pc);
          chk("sb_instr", bus0.dec_instr, e.instr);
        end
      end
      if (rv) load_stream(rpc & ~32'h3);
    end
    chk("sb_progress", 32'(hs >= 15), 32'h1);

    // ---- Cycle-exact table: back-pressure, redirect, halt, halt+redirect ----
    do_reset();
    for (int i = 0; i < 23; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      drive0(vt[i].rdy, vt[i].halt, vt[i].rv, vt[i].rpc);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(bus0.dec_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_pc", i),    bus0.dec_pc,         vt[i].epc);
      chk($sformatf("vec%0d_instr", i), bus0.dec_instr,      vt[i].ev ? word_at(vt[i].epc) : 32'h0);
      chk($sformatf("vec%0d_addr", i),  bus0.imem_addr,      vt[i].eaddr);
    end

    // ---- Asynchronous reset mid-cycle with the FIFO full ----
    @(posedge clk); #1;
    drive0(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_arst_valid", 32'(bus0.dec_valid), 32'h1);
    nrst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus0.dec_valid), 32'h0);
    chk("arst_pc",    bus0.dec_pc,         32'h0);
    chk("arst_addr",  bus0.imem_addr,      32'h0);
    @(posedge clk); #1;
    nrst = 1'b1;
    drive0(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("post_arst_c0_valid", 32'(bus0.dec_valid), 32'h0);
    @(negedge clk);
    chk("post_arst_c1_valid", 32'(bus0.dec_valid), 32'h1);
    chk("post_arst_c1_pc",    bus0.dec_pc,         32'h0);
    chk("post_arst_c1_instr", bus0.dec_instr,      32'h1000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
